packmem_rd_sched: RTL and testbench

- Shares one pipelined packet-memory read port between N_REQ axis_cpu cores (one requester port per core's LD/LDX path).
- Each requester has at most one read outstanding, matching the one-waiter-at-a-time rule in the writeback stage.
- Grants are round-robin; each returning word is routed to its requester by a tag pipeline.
- Results are held until acknowledged (vld/ack pattern, as with the ALU); a branch-mispredict flush can squash a requester's outstanding read.

---
 rtl/packmem_rd_sched_pkg.sv | 21 ++
 rtl/packmem_rd_sched_rr_arbiter.sv | 50 +++++
 rtl/packmem_rd_sched.sv | 125 ++++++++++++
 tb/tb_packmem_rd_sched.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packmem_rd_sched_pkg.sv
// Shared definitions for the packet-memory read scheduler: requester FSM
// states and access-size encodings used by the axis_cpu LD/LDX path.
package packmem_rd_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_INFLIGHT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_DONE     = 2'd3
  } req_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // The unused encoding 3 is folded onto a full-word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'd3) ? SIZE_WORD : size;
  endfunction

endpackage

// File: rtl/packmem_rd_sched_rr_arbiter.sv
// Round-robin arbiter: one grant per cycle to the first eligible requester
// at or after rr_ptr; the pointer moves past the winner only when advanced.
module packmem_rd_sched_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] eligible_i,
  input  logic             advance_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [PTR_W-1:0] grant_idx_o,
  output logic             grant_vld_o
);

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

  // Explicit wrap keeps the search correct for non-power-of-two N_REQ.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    int sum = int'(base) + off;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return PTR_W'(sum);
  endfunction

  always_comb begin
    // NOTE: every output gets a default before any conditional so no latch is inferred.
    grant_vld_o = 1'b0;
    grant_idx_o = '0;
    grant_o     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!grant_vld_o && eligible_i[wrap_add(rr_ptr_q, k)]) begin
        grant_vld_o = 1'b1;
        grant_idx_o = wrap_add(rr_ptr_q, k);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      grant_o[i] = grant_vld_o && (grant_idx_o == PTR_W'(i));
    end
    rr_ptr_d = rr_ptr_q;
    if (advance_i) begin
      rr_ptr_d = (grant_idx_o == PTR_W'(N_REQ - 1)) ? '0 : grant_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/packmem_rd_sched.sv
// Shares one pipelined packet-memory read port between N_REQ cores; each core
// has at most one read outstanding, results are held until acked or flushed.
module packmem_rd_sched
  import packmem_rd_sched_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LAT     = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_vld,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*2-1:0]          req_size,
  output logic [N_REQ-1:0]            req_rdy,
  input  logic [N_REQ-1:0]            req_flush,
  output logic [N_REQ-1:0]            resp_vld,
  output logic [N_REQ*DATA_WIDTH-1:0] resp_data,
  input  logic [N_REQ-1:0]            resp_ack,
  output logic                        mem_rd_en,
  output logic [ADDR_WIDTH-1:0]       mem_rd_addr,
  output logic [1:0]                  mem_rd_size,
  input  logic [DATA_WIDTH-1:0]       mem_rd_data
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  req_state_e            state_q  [N_REQ];
  logic [DATA_WIDTH-1:0] data_q   [N_REQ];
  logic [RD_LAT:0]       tag_vld_q;
  logic [PTR_W-1:0]      tag_idx_q[RD_LAT+1];

  logic [N_REQ-1:0]      eligible, grant, ret_hit;
  logic [PTR_W-1:0]      grant_idx;
  logic                  grant_vld;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [1:0]            sel_size;

  always_comb begin
    resp_data = '0;
    sel_addr  = '0;
    sel_size  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_rdy[i]  = (state_q[i] == ST_IDLE);
      resp_vld[i] = (state_q[i] == ST_DONE);
      resp_data[i*DATA_WIDTH +: DATA_WIDTH] = data_q[i];
      // Head of the tag pipe names the owner of the word on mem_rd_data now.
      ret_hit[i] = tag_vld_q[0] && (tag_idx_q[0] == PTR_W'(i));
      if (grant[i]) begin
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_size = req_size[2*i +: 2];
      end
    end
    eligible = req_vld & req_rdy & ~req_flush;
  end

  packmem_rd_sched_rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .eligible_i  (eligible),
    .advance_i   (grant_vld),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_vld_o (grant_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      mem_rd_size <= '0;
      tag_vld_q   <= '0;
      for (int k = 0; k <= RD_LAT; k++) tag_idx_q[k] <= '0;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      mem_rd_en <= grant_vld;
      if (grant_vld) begin
        mem_rd_addr <= sel_addr;
        mem_rd_size <= norm_size(sel_size);
      end
      for (int k = 0; k < RD_LAT; k++) begin
        tag_vld_q[k] <= tag_vld_q[k+1];
        tag_idx_q[k] <= tag_idx_q[k+1];
      end
      tag_vld_q[RD_LAT] <= grant_vld;
      tag_idx_q[RD_LAT] <= grant_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        state_q[i] <= ST_IDLE;
        // NOTE: result buffers are plain flops rather than RAM, so they can take the reset.
        data_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        unique case (state_q[i])
          ST_IDLE:     if (grant[i]) state_q[i] <= ST_INFLIGHT;
          ST_INFLIGHT: begin
            if (ret_hit[i]) begin
              if (req_flush[i]) begin
                state_q[i] <= ST_IDLE;
              end else begin
                state_q[i] <= ST_DONE;
                data_q[i]  <= mem_rd_data;
              end
            end else if (req_flush[i]) begin
              state_q[i] <= ST_DRAIN;
            end
          end
          ST_DRAIN:    if (ret_hit[i]) state_q[i] <= ST_IDLE;
          ST_DONE:     if (resp_ack[i] || req_flush[i]) state_q[i] <= ST_IDLE;
          default:     state_q[i] <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_packmem_rd_sched.sv
// Bench for packmem_rd_sched with three requesters: directed scenarios plus
// random traffic, all checked against a due-cycle reference model.
module tb_packmem_rd_sched;

  localparam int N  = 3;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int RL = 2;
  localparam int L  = RL + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_vld, req_flush, resp_ack;
  logic [N*AW-1:0] req_addr;
  logic [N*2-1:0]  req_size;
  logic [N-1:0]    req_rdy, resp_vld;
  logic [N*DW-1:0] resp_data;
  logic            mem_rd_en;
  logic [AW-1:0]   mem_rd_addr;
  logic [1:0]      mem_rd_size;
  logic [DW-1:0]   mem_rd_data;

  packmem_rd_sched #(
    .N_REQ (N), .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .RD_LAT (RL)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .req_vld (req_vld), .req_addr (req_addr), .req_size (req_size),
    .req_rdy (req_rdy), .req_flush (req_flush),
    .resp_vld (resp_vld), .resp_data (resp_data), .resp_ack (resp_ack),
    .mem_rd_en (mem_rd_en), .mem_rd_addr (mem_rd_addr),
    .mem_rd_size (mem_rd_size), .mem_rd_data (mem_rd_data)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // Reference model: each requester is free, waiting for a due cycle, or holding a word.
  bit            m_busy[N], m_pend[N], m_squash[N], m_held[N];
  int            m_due[N];
  logic [DW-1:0] m_want[N], m_data[N];
  int            m_ptr, last_grant;
  bit            x_en;
  logic [AW-1:0] x_addr;
  logic [1:0]    x_size;

  logic [DW-1:0] ring_data[L];
  bit            ring_vld[L];
  logic [AW-1:0] gq[$];

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a, input logic [1:0] s);
    return {a, 4'h5, a ^ 12'hA5C, 2'b00, s};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 0; m_pend[i] = 0; m_squash[i] = 0; m_held[i] = 0;
    end
    m_ptr = 0; last_grant = -1; x_en = 0;
  endtask

  task automatic idle_inputs();
    req_vld = '0; req_flush = '0; resp_ack = '0;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [1:0] s);
    req_vld[i] = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_size[i*2 +: 2] = s;
  endtask

  task automatic drive_mem();
    int slot = cyc % L;
    mem_rd_data = ring_vld[slot] ? ring_data[slot] : DW'($urandom);
    ring_vld[slot] = 0;
  endtask

  task automatic schedule_mem();
    if (mem_rd_en) begin
      ring_data[(cyc + RL) % L] = mem_word(mem_rd_addr, mem_rd_size);
      ring_vld[(cyc + RL) % L]  = 1;
    end
  endtask

  task automatic model_step();
    int g = -1;
    for (int k = 0; k < N; k++) begin
      int j = (m_ptr + k) % N;
      if (g < 0 && req_vld[j] && !m_busy[j] && !req_flush[j]) g = j;
    end
    for (int i = 0; i < N; i++) begin
      if (m_held[i]) begin
        if (resp_ack[i] || req_flush[i]) begin m_held[i] = 0; m_busy[i] = 0; end
      end else if (m_pend[i]) begin
        if (req_flush[i]) m_squash[i] = 1;
        if (cyc == m_due[i]) begin
          m_pend[i] = 0;
          if (m_squash[i]) m_busy[i] = 0;
          else begin m_held[i] = 1; m_data[i] = m_want[i]; end
        end
      end
    end
    last_grant = g;
    x_en = (g >= 0);
    if (g >= 0) begin
      x_addr = req_addr[g*AW +: AW];
      x_size = (req_size[g*2 +: 2] == 2'd3) ? 2'd2 : req_size[g*2 +: 2];
      m_busy[g] = 1; m_pend[g] = 1; m_squash[g] = 0;
      m_due[g]  = cyc + 1 + RL;
      m_want[g] = mem_word(x_addr, x_size);
      m_ptr = (g + 1) % N;
    end
  endtask

  // One clock cycle: compare registered outputs, then advance model and DUT.
  task automatic tick();
    logic [N-1:0]    e_rdy, e_vld;
    logic [N*DW-1:0] e_data, mask;
    drive_mem();
    e_data = '0; mask = '0;
    for (int i = 0; i < N; i++) begin
      e_rdy[i] = !m_busy[i];
      e_vld[i] = m_held[i];
      if (m_held[i]) begin
        e_data[i*DW +: DW] = m_data[i];
        mask[i*DW +: DW]   = '1;
      end
    end
    check("req_rdy", req_rdy, e_rdy);
    check("resp_vld", resp_vld, e_vld);
    check("resp_data", resp_data & mask, e_data);
    check("mem_rd_en", mem_rd_en, x_en);
    if (x_en) check("mem_rd_addr_size", {mem_rd_addr, mem_rd_size}, {x_addr, x_size});
    schedule_mem();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_all_reset(input string tag);
    check({tag, "_rdy_vld"}, {req_rdy, resp_vld}, {3'b111, 3'b000});
    check({tag, "_mem"}, {mem_rd_en, mem_rd_addr, mem_rd_size}, '0);
    check({tag, "_data"}, resp_data, '0);
  endtask

  // Asynchronous reset pulse raised mid-cycle and released after the next edge.
  task automatic reset_pulse();
    drive_mem();
    schedule_mem();
    rst_n = 1'b0;
    #1;
    check_all_reset("reset_mid");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      resp_ack = resp_vld;
      tick();
    end
    resp_ack = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    req_addr = '0; req_size = '0; mem_rd_data = '0;
    for (int s = 0; s < L; s++) ring_vld[s] = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_reset("reset_init");
    rst_n = 1'b1;

    // Single request: grant in cycle 0, memory strobe in 1, result in 4.
    set_req(0, 12'h010, 2'd2);
    tick();
    idle_inputs();
    check("single_mem", {mem_rd_en, mem_rd_addr, mem_rd_size}, {1'b1, 12'h010, 2'd2});
    repeat (3) tick();
    check("single_resp", {resp_vld, resp_data[31:0]}, {3'b001, mem_word(12'h010, 2'd2)});
    repeat (2) tick();
    check("single_hold", {resp_vld, req_rdy[0]}, {3'b001, 1'b0});
    resp_ack[0] = 1'b1;
    tick();
    resp_ack = '0;
    check("single_ack", {resp_vld[0], req_rdy[0]}, 2'b01);
    tick();

    // Contention: requesters 0 and 1 always asking, results acked at once.
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (last_grant == i || !req_vld[i]) set_req(i, AW'($urandom), 2'($urandom));
      end
      resp_ack = resp_vld;
      tick();
    end
    idle_inputs();
    drain(6);

    // Flush while INFLIGHT, with requester 0 reading alongside.
    set_req(1, 12'h222, 2'd1);
    tick();
    idle_inputs();
    set_req(0, 12'h111, 2'd2);
    tick();
    idle_inputs();
    req_flush[1] = 1'b1;
    tick();
    req_flush = '0;
    tick();
    check("flush_inflight", {req_rdy[1], resp_vld[1]}, 2'b10);
    drain(4);

    // Flush coincident with data return.
    set_req(0, 12'h0A0, 2'd0);
    tick();
    idle_inputs();
    repeat (2) tick();
    req_flush[0] = 1'b1;
    tick();
    req_flush = '0;
    check("flush_return", {req_rdy[0], resp_vld[0]}, 2'b10);

    // Flush while DONE, then fresh reads must not see stale words.
    set_req(1, 12'h0B0, 2'd3);
    tick();
    idle_inputs();
    repeat (3) tick();
    check("done_before_flush", resp_vld[1], 1'b1);
    req_flush[1] = 1'b1;
    tick();
    req_flush = '0;
    check("flush_done", {req_rdy[1], resp_vld[1]}, 2'b10);
    set_req(0, 12'h0C0, 2'd1);
    set_req(1, 12'h0D0, 2'd2);
    tick();
    tick();
    idle_inputs();
    drain(7);

    // Reset with two tags in the pipeline.
    set_req(0, 12'h044, 2'd2);
    tick();
    idle_inputs();
    set_req(1, 12'h055, 2'd2);
    tick();
    idle_inputs();
    reset_pulse();
    repeat (4) tick();
    check("post_reset_quiet", resp_vld, 3'b000);

    // Grant to 0 moves the pointer to 1; then 0 and 2 contend with 1 idle.
    set_req(0, 12'h0F0, 2'd2);
    tick();
    idle_inputs();
    drain(6);
    set_req(0, 12'h100, 2'd2);
    set_req(2, 12'h300, 2'd2);
    for (int n = 0; n < 16; n++) begin
      resp_ack = resp_vld;
      if (mem_rd_en) gq.push_back(mem_rd_addr);
      tick();
    end
    idle_inputs();
    drain(6);
    check("rr_grant_0", gq[0], 12'h300);
    check("rr_grant_1", gq[1], 12'h100);
    check("rr_grant_2", gq[2], 12'h300);

    // Random traffic: requests, withdrawals, flushes and late acks.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_vld[i] || last_grant == i) begin
          req_addr[i*AW +: AW] = AW'($urandom);
          req_size[i*2 +: 2]   = 2'($urandom);
        end
        req_vld[i]   = ($urandom_range(0, 3) != 0);
        req_flush[i] = ($urandom_range(0, 15) == 0);
        resp_ack[i]  = resp_vld[i] && ($urandom_range(0, 1) == 1);
      end
      tick();
    end
    idle_inputs();
    drain(8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
